// File: rtl/uart_frame_parser.sv
// Frame decoder behind the UART receiver: HDR, CMD, LEN, LEN payload bytes, CHK.
// Streams payload bytes and ends every frame with a frame_ok or frame_err pulse.
module uart_frame_parser #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 156000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_Byte,
  input  logic       Rx_done,
  output logic [7:0] cmd,
  output logic [7:0] frame_len,
  output logic [7:0] pld_data,
  output logic       pld_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned    TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMR_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]  TMR_ONE   = TW'(1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    pld_data_q, pld_data_d;
  logic          pld_valid_q, pld_valid_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  // Modulo-256 checksum accumulation; carry is intentionally dropped.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sum_q       <= 8'd0;
      rem_q       <= 8'd0;
      timer_q     <= '0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      pld_data_q  <= 8'd0;
      pld_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      pld_data_q  <= pld_data_d;
      pld_valid_q <= pld_valid_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  // Next-state and output decode; a strobe always beats a terminal timer count.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    pld_data_d  = pld_data_q;
    pld_valid_d = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;

    if (Rx_done) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (data_Byte == HDR_BYTE) begin
            state_d = ST_CMD;
            sum_d   = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_d   = data_Byte;
          sum_d   = data_Byte;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          len_d = data_Byte;
          if (data_Byte > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else if (data_Byte == 8'd0) begin
            sum_d   = sum8(sum_q, data_Byte);
            state_d = ST_CHK;
          end else begin
            sum_d   = sum8(sum_q, data_Byte);
            rem_d   = data_Byte;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pld_data_d  = data_Byte;
          pld_valid_d = 1'b1;
          sum_d       = sum8(sum_q, data_Byte);
          rem_d       = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CHK: begin
          if (data_Byte == sum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
  end

  assign cmd       = cmd_q;
  assign frame_len = len_q;
  assign pld_data  = pld_data_q;
  assign pld_valid = pld_valid_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed, table-driven bench for uart_frame_parser (TIMEOUT_CYC=100, MAX_LEN=16).
module tb_uart_frame_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_Byte;
  logic       Rx_done;
  logic [7:0] cmd;
  logic [7:0] frame_len;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int checks;
  int failures;

  uart_frame_parser #(
    .HDR_BYTE   (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_Byte(data_Byte),
    .Rx_done  (Rx_done),
    .cmd      (cmd),
    .frame_len(frame_len),
    .pld_data (pld_data),
    .pld_valid(pld_valid),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pv;
    logic [7:0] pd;
    logic       ok;
    logic       err;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic pv, input logic [7:0] pd,
                              input logic ok, input logic err, input logic [1:0] code,
                              input logic [7:0] c, input logic [7:0] l);
    vec_t v;
    v.d = d; v.pv = pv; v.pd = pd; v.ok = ok; v.err = err; v.code = code; v.cmd = c; v.len = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one strobe at a falling edge; returns at the next falling edge, where the response is visible.
  task automatic strobe(input logic [7:0] d);
    data_Byte = d;
    Rx_done   = 1'b1;
    @(negedge clk);
    Rx_done   = 1'b0;
    data_Byte = 8'h00;
  endtask

  task automatic quiet_cycle(input string tag);
    @(negedge clk);
    chk({tag, "_pv"},  {7'd0, pld_valid}, 8'd0);
    chk({tag, "_ok"},  {7'd0, frame_ok},  8'd0);
    chk({tag, "_err"}, {7'd0, frame_err}, 8'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"},  cmd,       8'd0);
    chk({tag, "_len"},  frame_len, 8'd0);
    chk({tag, "_pd"},   pld_data,  8'd0);
    chk({tag, "_pv"},   {7'd0, pld_valid}, 8'd0);
    chk({tag, "_ok"},   {7'd0, frame_ok},  8'd0);
    chk({tag, "_err"},  {7'd0, frame_err}, 8'd0);
    chk({tag, "_code"}, {6'd0, err_code},  8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    Rx_done   = 1'b0;
    data_Byte = 8'h00;

    // good frame
    tbl.push_back(mk(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h10, 8'h00));
    tbl.push_back(mk(8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h44, 1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h89, 1'b0, 8'h44, 1'b1, 1'b0, 2'd0, 8'h10, 8'h02));
    // bad checksum
    tbl.push_back(mk(8'hA5, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h10, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h02, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h44, 1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 8'h10, 8'h02));
    tbl.push_back(mk(8'h88, 1'b0, 8'h44, 1'b0, 1'b1, 2'd1, 8'h10, 8'h02));
    // leading garbage, zero length
    tbl.push_back(mk(8'h00, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h10, 8'h02));
    tbl.push_back(mk(8'hFF, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h10, 8'h02));
    tbl.push_back(mk(8'h5A, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h10, 8'h02));
    tbl.push_back(mk(8'hA5, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h10, 8'h02));
    tbl.push_back(mk(8'h20, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h20, 8'h02));
    tbl.push_back(mk(8'h00, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h20, 8'h00));
    tbl.push_back(mk(8'h20, 1'b0, 8'h44, 1'b1, 1'b0, 2'd1, 8'h20, 8'h00));
    // length violation, then recovery
    tbl.push_back(mk(8'hA5, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h20, 8'h00));
    tbl.push_back(mk(8'h01, 1'b0, 8'h44, 1'b0, 1'b0, 2'd1, 8'h01, 8'h00));
    tbl.push_back(mk(8'h11, 1'b0, 8'h44, 1'b0, 1'b1, 2'd2, 8'h01, 8'h11));
    tbl.push_back(mk(8'hA5, 1'b0, 8'h44, 1'b0, 1'b0, 2'd2, 8'h01, 8'h11));
    tbl.push_back(mk(8'h01, 1'b0, 8'h44, 1'b0, 1'b0, 2'd2, 8'h01, 8'h11));
    tbl.push_back(mk(8'h01, 1'b0, 8'h44, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'h7E, 1'b1, 8'h7E, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'h80, 1'b0, 8'h7E, 1'b1, 1'b0, 2'd2, 8'h01, 8'h01));
    // header value as payload data
    tbl.push_back(mk(8'hA5, 1'b0, 8'h7E, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'hA7, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd2, 8'h01, 8'h01));
    // header value as command
    tbl.push_back(mk(8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2, 8'h01, 8'h01));
    tbl.push_back(mk(8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2, 8'hA5, 8'h01));
    tbl.push_back(mk(8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 2'd2, 8'hA5, 8'h00));
    tbl.push_back(mk(8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 2'd2, 8'hA5, 8'h00));

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    quiet_cycle("post_reset");

    foreach (tbl[i]) begin
      strobe(tbl[i].d);
      chk($sformatf("v%0d_pv", i),   {7'd0, pld_valid}, {7'd0, tbl[i].pv});
      chk($sformatf("v%0d_pd", i),   pld_data,          tbl[i].pd);
      chk($sformatf("v%0d_ok", i),   {7'd0, frame_ok},  {7'd0, tbl[i].ok});
      chk($sformatf("v%0d_err", i),  {7'd0, frame_err}, {7'd0, tbl[i].err});
      chk($sformatf("v%0d_code", i), {6'd0, err_code},  {6'd0, tbl[i].code});
      chk($sformatf("v%0d_cmd", i),  cmd,               tbl[i].cmd);
      chk($sformatf("v%0d_len", i),  frame_len,         tbl[i].len);
      quiet_cycle($sformatf("v%0d_gap", i));
    end

    // timeout: error exactly 100 cycles after the last accepted byte
    strobe(8'hA5);
    quiet_cycle("tmo_hdr");
    strobe(8'h10);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_early_%0d", k), {7'd0, frame_err}, 8'd0);
    end
    @(negedge clk);
    chk("tmo_err",  {7'd0, frame_err}, 8'd1);
    chk("tmo_code", {6'd0, err_code},  8'd3);
    chk("tmo_ok",   {7'd0, frame_ok},  8'd0);
    quiet_cycle("tmo_after");

    // timeout race: strobe on the terminal cycle is taken as LEN
    strobe(8'hA5);
    quiet_cycle("race_hdr");
    strobe(8'h10);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      chk($sformatf("race_early_%0d", k), {7'd0, frame_err}, 8'd0);
    end
    strobe(8'h03);
    chk("race_err", {7'd0, frame_err}, 8'd0);
    chk("race_len", frame_len, 8'h03);
    quiet_cycle("race_gap");
    strobe(8'h01);
    chk("race_p0", pld_data, 8'h01);
    strobe(8'h02);
    chk("race_p1", pld_data, 8'h02);
    strobe(8'h03);
    chk("race_p2_pv", {7'd0, pld_valid}, 8'd1);
    strobe(8'h19);
    chk("race_ok",  {7'd0, frame_ok},  8'd1);
    chk("race_err2", {7'd0, frame_err}, 8'd0);
    chk("race_code", {6'd0, err_code},  8'd3);

    // reset in the middle of a frame
    strobe(8'hA5);
    strobe(8'h10);
    strobe(8'h03);
    strobe(8'h11);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    quiet_cycle("rst_rel0");
    quiet_cycle("rst_rel1");
    strobe(8'hA5);
    strobe(8'h30);
    chk("rst_cmd", cmd, 8'h30);
    strobe(8'h00);
    chk("rst_len", frame_len, 8'h00);
    strobe(8'h30);
    chk("rst_ok",   {7'd0, frame_ok},  8'd1);
    chk("rst_err",  {7'd0, frame_err}, 8'd0);
    chk("rst_pv",   {7'd0, pld_valid}, 8'd0);
    chk("rst_code", {6'd0, err_code},  8'd0);
    quiet_cycle("rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Frame decoder directly downstream of the 16x-oversampling UART receiver. Consumes the receiver's byte output and one-cycle done strobe, and locates frames of the form HDR, CMD, LEN, LEN payload bytes, CHK. Payload is streamed out byte by byte. Each frame ends with a pass pulse or an error pulse, for the command/register logic behind it.

Parameters:
HDR_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, largest legal LEN value (1..255).
TIMEOUT_CYC, 156000, inter-byte idle limit in clk cycles while inside a frame (3 byte times at 9600 baud / 50 MHz); counter width is $clog2(TIMEOUT_CYC+1).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
data_Byte  input  8  received byte; valid only in the cycle Rx_done=1.
Rx_done  input  1  one-cycle strobe from receiver; no back-pressure. Spacing is at least 1 byte time.
cmd  output  8  CMD byte of current/last frame; latched when the CMD byte is accepted, held otherwise.
frame_len  output  8  LEN of current/last frame; latched when the LEN byte is accepted.
pld_data  output  8  payload byte; valid with pld_valid.
pld_valid  output  1  one-cycle pulse per payload byte.
frame_ok  output  1  one-cycle pulse: frame complete, checksum correct.
frame_err  output  1  one-cycle pulse: frame aborted.
err_code  output  2  1=checksum, 2=length, 3=timeout. Updated with frame_err and held until the next frame_err.

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, all outputs 0, checksum/timer/byte counter 0. A partial frame is discarded with no pulse.
- All outputs are registered. Each response appears exactly 1 cycle after the Rx_done cycle that caused it.
- States: IDLE, CMD, LEN, PAYLOAD, CHK. Transitions happen only on Rx_done, except for timeout.
- IDLE: a byte equal to HDR_BYTE goes to CMD and clears sum to 0. Any other byte is dropped silently, with no error.
- CMD: any byte, including HDR_BYTE, is taken as the command. Latch cmd, set sum=byte, go to LEN.
- LEN:
  - Byte > MAX_LEN: frame_err, err_code=2, go to IDLE. frame_len is still latched.
  - Byte == 0: sum+=byte, go to CHK.
  - Otherwise: latch frame_len, sum+=byte, load remaining=byte, go to PAYLOAD.
- PAYLOAD: each byte drives pld_data=byte and pld_valid=1, sum+=byte, remaining-=1. Go to CHK when the last byte is accepted (remaining was 1). HDR_BYTE inside the payload is plain data.
- CHK:
  - Byte == sum: frame_ok.
  - Otherwise: frame_err, err_code=1.
  - Either way, go to IDLE.
- Checksum: 8-bit sum of CMD, LEN and all payload bytes, modulo 256 (carry discarded).
- Timeout: the timer runs only outside IDLE. It is cleared on every Rx_done and on entry to CMD. When TIMEOUT_CYC cycles pass after the last accepted byte with no Rx_done, the block pulses frame_err with err_code=3 and returns to IDLE. If Rx_done coincides with the terminal count, the byte wins: it is processed and the timer clears.
- The downstream consumer must discard streamed payload when frame_err follows. The parser does no buffering.
- frame_ok and frame_err are mutually exclusive. pld_valid never coincides with either of them.
- A new HDR_BYTE is recognised on the Rx_done immediately after a frame ends; there is no dead cycle.

Test Plan:
- Good frame (TIMEOUT_CYC=100 in bench): bytes A5 10 02 33 44 89 -> pld_valid twice (33, 44), cmd=10, frame_len=02, frame_ok pulse 1 cycle after the 89 strobe, frame_err never.
- Bad checksum: A5 10 02 33 44 88 -> two pld_valid pulses, then frame_err with err_code=1, no frame_ok.
- Zero length and leading garbage: 00 FF 5A A5 20 00 20 -> first three bytes ignored; frame_ok, no pld_valid, cmd=20, frame_len=00.
- Length violation (MAX_LEN=16): A5 01 11 -> frame_err with err_code=2 1 cycle after the LEN strobe. A following A5 01 01 7E 80 -> frame_ok.
- Timeout: A5 10 then idle -> frame_err with err_code=3 exactly 100 cycles after the 10 strobe. Variant: next strobe lands on cycle 100 -> no error, byte taken as LEN.
- Reset mid-frame: A5 10 03 11, assert rst_n=0 for 1 cycle, then A5 30 00 30 -> all outputs 0 during reset, no pulse from the partial frame, frame_ok for the new frame with cmd=30.
